// File: rtl/fft_peak_collector.sv
// rtl/fft_peak_collector.sv - captures 16-bin FFT frames, streams bins out, tracks peak bin
//
// Purpose: consuming end of the parallel FFT interface. A full 16-bin complex
// frame is latched on fft_valid, replayed one bin per valid/ready transfer,
// and the largest-magnitude bin of each frame is published on freq. done
// pulses once every FRAMES completed frames.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   fft_valid           one-cycle strobe, fft_d0..fft_d15 hold a full frame
//   fft_d0..fft_d15     bin k complex value {re, im}, DW bits each, signed
//   fft_ready           high while a frame can be captured (IDLE)
//   bin_valid/bin_ready bin stream handshake
//   bin_data/bin_idx    buffered bin value and its index
//   freq                peak bin index of the last completed frame
//   done                one-cycle pulse at the end of frame FRAMES of a run
//   overrun             sticky: frame offered while busy streaming
module fft_peak_collector #(
  parameter int DW     = 16,
  parameter int FRAMES = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fft_valid,
  input  logic [2*DW-1:0] fft_d0,
  input  logic [2*DW-1:0] fft_d1,
  input  logic [2*DW-1:0] fft_d2,
  input  logic [2*DW-1:0] fft_d3,
  input  logic [2*DW-1:0] fft_d4,
  input  logic [2*DW-1:0] fft_d5,
  input  logic [2*DW-1:0] fft_d6,
  input  logic [2*DW-1:0] fft_d7,
  input  logic [2*DW-1:0] fft_d8,
  input  logic [2*DW-1:0] fft_d9,
  input  logic [2*DW-1:0] fft_d10,
  input  logic [2*DW-1:0] fft_d11,
  input  logic [2*DW-1:0] fft_d12,
  input  logic [2*DW-1:0] fft_d13,
  input  logic [2*DW-1:0] fft_d14,
  input  logic [2*DW-1:0] fft_d15,
  output logic            fft_ready,
  output logic            bin_valid,
  input  logic            bin_ready,
  output logic [2*DW-1:0] bin_data,
  output logic [3:0]      bin_idx,
  output logic [3:0]      freq,
  output logic            done,
  output logic            overrun
);

  localparam int CW = $clog2(FRAMES + 1);
  localparam logic [CW-1:0] LAST_FRAME = CW'(FRAMES - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state;
  logic [3:0]      idx;
  logic [2*DW-1:0] peak_mag;
  logic [3:0]      peak_idx;
  logic [CW-1:0]   frame_cnt;
  logic [2*DW-1:0] frame_buf [16];

  logic            capture;
  logic            xfer;
  logic signed [DW-1:0]   re, im;
  logic signed [2*DW-1:0] re_x, im_x, re_sq, im_sq;
  logic [2*DW-1:0] mag;
  logic            is_new_peak;
  logic [3:0]      final_peak;

  assign capture   = (state == IDLE) && fft_valid;
  assign xfer      = bin_valid && bin_ready;
  assign fft_ready = (state == IDLE);
  assign bin_idx   = idx;
  // Buffer has no reset, so gate the mux to keep bin_data at zero when idle.
  assign bin_data  = bin_valid ? frame_buf[idx] : '0;

  // Each square is non-negative and at most 2^(2DW-2), so the sum fits in
  // 2*DW bits when read as unsigned.
  assign re    = bin_data[2*DW-1:DW];
  assign im    = bin_data[DW-1:0];
  assign re_x  = {{DW{re[DW-1]}}, re};
  assign im_x  = {{DW{im[DW-1]}}, im};
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;
  assign mag   = $unsigned(re_sq) + $unsigned(im_sq);

  // Strict compare keeps the lower index on ties; final_peak folds in the
  // bin being transferred so bin 15 counts on the last edge.
  assign is_new_peak = mag > peak_mag;
  assign final_peak  = is_new_peak ? idx : peak_idx;

  always_ff @(posedge clk) begin
    if (capture) begin
      frame_buf[0]  <= fft_d0;
      frame_buf[1]  <= fft_d1;
      frame_buf[2]  <= fft_d2;
      frame_buf[3]  <= fft_d3;
      frame_buf[4]  <= fft_d4;
      frame_buf[5]  <= fft_d5;
      frame_buf[6]  <= fft_d6;
      frame_buf[7]  <= fft_d7;
      frame_buf[8]  <= fft_d8;
      frame_buf[9]  <= fft_d9;
      frame_buf[10] <= fft_d10;
      frame_buf[11] <= fft_d11;
      frame_buf[12] <= fft_d12;
      frame_buf[13] <= fft_d13;
      frame_buf[14] <= fft_d14;
      frame_buf[15] <= fft_d15;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bin_valid <= 1'b0;
      idx       <= 4'd0;
      peak_mag  <= '0;
      peak_idx  <= 4'd0;
      frame_cnt <= '0;
      freq      <= 4'd0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (fft_valid) begin
            idx       <= 4'd0;
            peak_mag  <= '0;
            peak_idx  <= 4'd0;
            bin_valid <= 1'b1;
            state     <= STREAM;
          end
        end
        STREAM: begin
          // A frame offered mid-stream is dropped; only the flag records it.
          if (fft_valid) overrun <= 1'b1;
          if (xfer) begin
            if (is_new_peak) begin
              peak_mag <= mag;
              peak_idx <= idx;
            end
            idx <= idx + 4'd1;
            if (idx == 4'd15) begin
              freq      <= final_peak;
              bin_valid <= 1'b0;
              state     <= IDLE;
              if (frame_cnt == LAST_FRAME) begin
                done      <= 1'b1;
                frame_cnt <= '0;
              end else begin
                frame_cnt <= frame_cnt + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_peak_collector.sv
// tb/tb_fft_peak_collector.sv - directed self-checking bench for fft_peak_collector
module tb_fft_peak_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fft_valid = 1'b0;
  logic [31:0] d [16];
  logic        fft_ready;
  logic        bin_valid;
  logic        bin_ready = 1'b1;
  logic [31:0] bin_data;
  logic [3:0]  bin_idx;
  logic [3:0]  freq;
  logic        done;
  logic        overrun;

  logic [31:0] exp_buf [16];
  logic [3:0]  prev_freq = 4'd0;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fft_peak_collector #(.DW(16), .FRAMES(10)) dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
    .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
    .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .fft_ready(fft_ready), .bin_valid(bin_valid), .bin_ready(bin_ready),
    .bin_data(bin_data), .bin_idx(bin_idx), .freq(freq), .done(done),
    .overrun(overrun)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_frame();
    for (int j = 0; j < 16; j++) d[j] = 32'h0;
  endtask

  // Called at a negedge; the capture edge is the following posedge.
  task automatic capture();
    check("fft_ready_idle", fft_ready, 1);
    for (int j = 0; j < 16; j++) exp_buf[j] = d[j];
    fft_valid = 1'b1;
    @(negedge clk);
    fft_valid = 1'b0;
    clear_frame();
  endtask

  // mode 0: bin_ready held high; mode 1: bin_ready pattern 1,0,0,1.
  // inj: bin index at which a competing frame is offered (16 = none).
  task automatic stream(input int mode, input int inj, input logic [3:0] exp_freq,
                        input logic exp_done, input logic exp_ovr);
    int k = 0;
    int c = 0;
    logic x;
    while (k < 16 && c < 100) begin
      fft_valid = 1'b0;
      bin_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      check("bin_valid", bin_valid, 1);
      check("bin_idx", bin_idx, k);
      check("bin_data", bin_data, exp_buf[k]);
      check("fft_ready_busy", fft_ready, 0);
      if (k == 15) check("freq_hold", freq, prev_freq);
      if (k == inj) begin
        d[9] = 32'h7FFF7FFF;
        fft_valid = 1'b1;
      end
      x = bin_ready;
      @(negedge clk);
      if (x) k++;
      c++;
    end
    fft_valid = 1'b0;
    bin_ready = 1'b1;
    check("stream_bound", k, 16);
    check("freq", freq, exp_freq);
    check("done", done, exp_done);
    check("fft_ready_after", fft_ready, 1);
    check("bin_valid_after", bin_valid, 0);
    check("overrun", overrun, exp_ovr);
    prev_freq = exp_freq;
    @(negedge clk);
    check("done_pulse_len", done, 0);
    check("bin_valid_idle", bin_valid, 0);
  endtask

  initial begin
    clear_frame();
    #1;
    check("rst_fft_ready", fft_ready, 1);
    check("rst_bin_valid", bin_valid, 0);
    check("rst_bin_data", bin_data, 0);
    check("rst_bin_idx", bin_idx, 0);
    check("rst_freq", freq, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single peak at bin 5.
    clear_frame();
    d[5] = 32'h01000000;
    capture();
    stream(0, 16, 4'd5, 1'b0, 1'b0);

    // Tie between bins 3 and 9 keeps the lower index.
    clear_frame();
    d[3] = 32'h00100010;
    d[9] = 32'h00100010;
    capture();
    stream(0, 16, 4'd3, 1'b0, 1'b0);

    // Most negative components on bin 15 beat 0x7FFF elsewhere.
    for (int j = 0; j < 15; j++) d[j] = 32'h7FFF0000;
    d[15] = 32'h80008000;
    capture();
    stream(0, 16, 4'd15, 1'b0, 1'b0);

    // Backpressure with negative components; bin 12 (mag 36) wins.
    clear_frame();
    d[2]  = 32'hFFFB0000;
    d[7]  = 32'h00050003;
    d[12] = 32'h0000FFFA;
    capture();
    stream(1, 16, 4'd12, 1'b0, 1'b0);

    // Overrun: competing frame at bin 4 is dropped.
    clear_frame();
    d[4] = 32'h00200000;
    capture();
    stream(0, 4, 4'd4, 1'b0, 1'b1);
    @(negedge clk);
    check("overrun_sticky", overrun, 1);

    // Reset mid-stream at bin 7.
    clear_frame();
    d[6] = 32'h00400000;
    capture();
    for (int j = 0; j < 7; j++) @(negedge clk);
    check("pre_rst_bin_idx", bin_idx, 7);
    rst = 1'b1;
    #1;
    check("mid_rst_bin_valid", bin_valid, 0);
    check("mid_rst_bin_data", bin_data, 0);
    check("mid_rst_bin_idx", bin_idx, 0);
    check("mid_rst_fft_ready", fft_ready, 1);
    check("mid_rst_freq", freq, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    prev_freq = 4'd0;
    @(negedge clk);

    // Full run of 10 frames with the count restarted by reset.
    for (int f = 1; f <= 10; f++) begin
      clear_frame();
      if (f % 2 == 1) d[1] = 32'h00010000;
      else            d[15] = 32'h00010000;
      capture();
      stream(0, 16, (f % 2 == 1) ? 4'd1 : 4'd15, (f == 10), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fft_peak_collector.md
Name: fft_peak_collector

Overview:
- Sits downstream of the FAS core's FFT output port. Accepts one 16-bin complex spectrum frame per fft_valid strobe.
- Serialises the frame onto a valid/ready bin stream toward the host/readout logic.
- Computes the peak-magnitude bin of each frame and reports it on freq.
- Raises done after a programmed number of frames. This is the consuming end of the FAS parallel FFT interface.

Parameters:
- DW, 16, width of each real/imag component (signed two's complement); fft_d word = {real[2DW-1:DW], imag[DW-1:0]}
- FRAMES, 10, number of frames per analysis run before done

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- fft_valid  input  1  one-cycle strobe, fft_d0..fft_d15 hold a full frame
- fft_d0 .. fft_d15  input  2*DW each  bin k complex value {re, im}
- fft_ready  output  1  high when a frame can be captured
- bin_valid  output  1  bin_data/bin_idx valid
- bin_ready  input  1  downstream accepts current bin
- bin_data  output  2*DW  buffered bin value
- bin_idx  output  4  index of bin_data (0..15)
- freq  output  4  peak bin index of last completed frame
- done  output  1  one-cycle pulse at end of frame FRAMES of a run
- overrun  output  1  sticky: fft_valid arrived while fft_ready low

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, so fft_ready=1.
  - bin_valid=0, bin_data=0, bin_idx=0, freq=0, done=0, overrun=0.
  - frame count=0, peak registers cleared, buffer contents don't-care.
- States: IDLE, STREAM.
- IDLE:
  - fft_ready=1.
  - On fft_valid=1, all 16 words are registered into a 16x(2*DW) buffer at that edge.
  - idx=0, peak_mag=0, peak_idx=0; state goes to STREAM.
- STREAM:
  - fft_ready=0, bin_valid=1, bin_data=buf[idx], bin_idx=idx.
  - bin_data/bin_idx stay stable while bin_valid && !bin_ready.
  - Transfer occurs when bin_valid && bin_ready; idx increments.
- Magnitude:
  - mag = re*re + im*im, signed DW x DW products, unsigned 2*DW-bit sum. Max (-2^(DW-1))^2*2 = 2^(2DW-1) fits with no overflow.
  - Evaluated on each transfer. If mag > peak_mag (strictly greater), peak_mag/peak_idx update.
  - Ties keep the lower index; an all-zero frame gives peak_idx=0.
- Last transfer (idx=15):
  - freq <= final peak_idx. This includes bin 15 itself, resolved combinationally in the same edge.
  - frame count increments; state returns to IDLE, so fft_ready=1 the next cycle.
  - If frame count reaches FRAMES, done=1 for exactly that one cycle and frame count wraps to 0.
- Latency:
  - First bin_valid is 1 cycle after capture.
  - With bin_ready held high, 16 transfer cycles follow; the next frame can be captured 17 cycles after the previous capture.
  - freq/done update on the cycle after the last transfer edge.
- Overrun:
  - fft_valid=1 while state=STREAM drops that frame and sets overrun=1 until rst.
  - The in-progress stream is unaffected.
- freq holds its value between frames and across runs; only rst clears it.
- bin_ready is ignored in IDLE.
- Reset asserted mid-STREAM aborts immediately to the reset values above. The partial frame is discarded, not counted, and freq is not updated.

Test Plan:
- Single frame, fft_d5={0x0100,0x0000}, all others 0, bin_ready=1 -> bin_idx 0..15 on consecutive cycles with bin_data=buf[k]; freq=5 after the final transfer; fft_ready high 17 cycles after capture.
- Tie: fft_d3=fft_d9={0x0010,0x0010}, others 0 -> freq=3. Then fft_d15={0x8000,0x8000} (mag 0x80000000), others {0x7FFF,0} -> freq=15.
- Backpressure: bin_ready toggled 1,0,0,1 repeating -> bin_data/bin_idx stable while stalled; exactly 16 transfers, no skipped or duplicated index.
- Overrun: second fft_valid at bin_idx=4 of frame 1 -> frame dropped; overrun=1 sticky; frame 1 completes normally; frame count=1.
- Full run: 10 frames, peaks at 1 and 15 alternating -> done pulses exactly once, one cycle after frame 10's last transfer, with freq=15 (peak of frame 10).
- rst asserted at bin_idx=7 -> outputs at reset values immediately, fft_ready=1, freq=0; a new frame captures cleanly with frame count restarting at 0.
